biu_ahb3lite_bridge: RTL and testbench
======================================

// Module: biu_ahb3lite_bridge
// PURPOSE
//  Downstream stage of the no-data-cache core: converts its BIU request/ack interface into AHB3-Lite master transfers.
//  Pipelines one address phase over one data phase, so at most 2 transfers are in flight (matches core DEPTH=2).
//  Returns per-transfer ack/err and read data to the core, and handles the AHB two-cycle ERROR response.
// PARAMETERS
//  XLEN  32    data width of BIU and HWDATA/HRDATA (32 or 64)
//  ALEN  XLEN  address width of BIU and HADDR
// PORTS
//  clk_i          in   1     clock; single clock domain, all logic on posedge
//  rst_ni         in   1     asynchronous, active-low reset
//  biu_stb_i      in   1     transfer request from core
//  biu_stb_ack_o  out  1     request accepted this cycle (address phase issued)
//  biu_d_ack_o    out  1     write data consumed this cycle
//  biu_adri_i     in   ALEN  request address
//  biu_adro_o     out  ALEN  address of the transfer currently in data phase
//  biu_size_i     in   biu_size_t  transfer size
//  biu_type_i     in   biu_type_t  burst type; only SINGLE supported
//  biu_lock_i     in   1     locked transfer
//  biu_we_i       in   1     1=write
//  biu_prot_i     in   biu_prot_t  protection attributes
//  biu_d_i        in   XLEN  write data; sampled together with the request
//  biu_q_o        out  XLEN  read data; valid while biu_ack_o is high
//  biu_ack_o      out  1     data phase completed OK
//  biu_err_o      out  1     data phase completed with ERROR
//  HSEL           out  1     =1 when HTRANS!=IDLE
//  HADDR          out  ALEN  =biu_adri_i
//  HWDATA         out  XLEN  registered write data of the transfer in data phase
//  HRDATA         in   XLEN  read data
//  HWRITE         out  1     =biu_we_i
//  HSIZE          out  3     BYTE=0, HWORD=1, WORD=2, DWORD=3, QWORD=4
//  HBURST         out  3     always 3'b000 (SINGLE)
//  HPROT          out  4     [0]=~INSTRUCTION, [1]=PRIVILEGED, [2]=BUFFERABLE, [3]=CACHEABLE, from biu_prot_i
//  HTRANS         out  2     IDLE=2'b00 or NONSEQ=2'b10
//  HMASTLOCK      out  1     =biu_lock_i during an issued address phase
//  HREADY         in   1     transfer done / bus ready
//  HRESP          in   1     0=OKAY, 1=ERROR
// BEHAVIOUR
//  Registered state: dval (data phase pending), dwe, dwdata[XLEN], dadr[ALEN], errc (1st error cycle seen).
//  Reset (rst_ni=0, async): all state cleared; HTRANS=IDLE, HSEL=0, HMASTLOCK=0; stb_ack, d_ack, ack, err all 0.
//  Issue: issue = biu_stb_i & HREADY & ~(HRESP & ~HREADY) & ~errc.
//   - issue=1: HTRANS=NONSEQ, biu_stb_ack_o=1 (combinational, same cycle). Next cycle dval=1; dwe, dwdata, dadr are captured.
//   - issue=0: HTRANS=IDLE; HADDR/HWRITE/HSIZE are don't-care.
//  Data phase (dval=1):
//   - HREADY=1, HRESP=0: biu_ack_o=1, biu_q_o=HRDATA; biu_d_ack_o=dwe. dval <= issue in the same cycle (back-to-back transfers allowed).
//   - HREADY=0, HRESP=0: wait state; hold HWDATA; issue is blocked because it requires HREADY.
//   - HREADY=0, HRESP=1 (1st error cycle): force HTRANS=IDLE, no stb_ack, errc <= 1.
//   - HREADY=1, HRESP=1 (2nd error cycle): biu_err_o=1, ack=0, errc <= 0, dval <= 0.
//     No issue in this cycle, so the core's pending request is retried or discarded by the core.
//  biu_ack_o and biu_err_o are never both 1, and are only asserted while dval=1.
//  biu_adro_o = dadr. Throughput: 1 transfer/cycle with zero wait states. Latency: stb_ack to ack is 1 cycle minimum.
//  biu_type_i != SINGLE: transferred as SINGLE (no burst sequencing).
//  Reset mid-transfer: the pending data phase is dropped silently; no ack/err is generated.
// TESTING
//  1. Read, 0 wait: stb, adr=0x100, WORD, HRDATA=0xDEADBEEF -> C0 NONSEQ+stb_ack; C1 ack=1, q=0xDEADBEEF.
//  2. Back-to-back writes 0x10/0x14, d=0x11/0x22 -> NONSEQ on C0 and C1; HWDATA=0x11 on C1, 0x22 on C2; two acks with d_ack.
//  3. Read with 2 wait states -> HREADY low for C1-C2, no issue during them; ack on C3; next NONSEQ on C3 at earliest.
//  4. Write ERROR: HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> HTRANS IDLE on both cycles; err=1 on 2nd cycle only; no ack.
//  5. Sizes BYTE/HWORD/WORD/DWORD -> HSIZE=0/1/2/3; prot=DATA|PRIVILEGED -> HPROT=4'b0011; HMASTLOCK follows lock.
//  6. rst_ni low during a data phase with HREADY=0 -> dval=0 immediately; no ack after release; HTRANS=IDLE.

Source files
------------

// File: rtl/biu_ahb3lite_bridge.sv
// BIU request/ack to AHB3-Lite master bridge: one address phase pipelined over one data phase.
// Handles the two-cycle AHB ERROR response by blocking issue until the error completes.
module biu_ahb3lite_bridge #(
  parameter int XLEN = 32,
  parameter int ALEN = XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            biu_stb_i,
  output logic            biu_stb_ack_o,
  output logic            biu_d_ack_o,
  input  logic [ALEN-1:0] biu_adri_i,
  output logic [ALEN-1:0] biu_adro_o,
  input  logic [2:0]      biu_size_i,
  input  logic [2:0]      biu_type_i,
  input  logic            biu_lock_i,
  input  logic            biu_we_i,
  input  logic [3:0]      biu_prot_i,
  input  logic [XLEN-1:0] biu_d_i,
  output logic [XLEN-1:0] biu_q_o,
  output logic            biu_ack_o,
  output logic            biu_err_o,
  output logic            HSEL,
  output logic [ALEN-1:0] HADDR,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic            HMASTLOCK,
  input  logic            HREADY,
  input  logic            HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic            r_dval;
  logic            r_dwe;
  logic [XLEN-1:0] r_dwdata;
  logic [ALEN-1:0] r_dadr;
  logic            r_errc;

  logic w_err_first;
  logic w_issue;

  assign w_err_first = HRESP & ~HREADY;
  // Gated by rst_ni so nothing is issued while reset is held.
  assign w_issue     = rst_ni & biu_stb_i & HREADY & ~w_err_first & ~r_errc;

  assign biu_stb_ack_o = w_issue;
  assign HTRANS        = w_issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSEL          = w_issue;
  assign HMASTLOCK     = w_issue & biu_lock_i;
  assign HADDR         = biu_adri_i;
  assign HWRITE        = biu_we_i;
  assign HSIZE         = biu_size_i;
  // Bursts are not sequenced; every request goes out as SINGLE.
  assign HBURST        = biu_type_i & 3'b000;
  // prot bits: [0]=instruction, [1]=privileged, [2]=bufferable, [3]=cacheable
  assign HPROT         = {biu_prot_i[3], biu_prot_i[2], biu_prot_i[1], ~biu_prot_i[0]};

  assign HWDATA      = r_dwdata;
  assign biu_adro_o  = r_dadr;
  assign biu_q_o     = HRDATA;
  assign biu_ack_o   = r_dval & HREADY & ~HRESP;
  assign biu_err_o   = r_dval & HREADY & HRESP;
  assign biu_d_ack_o = r_dval & HREADY & ~HRESP & r_dwe;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dval   <= 1'b0;
      r_dwe    <= 1'b0;
      r_dwdata <= '0;
      r_dadr   <= '0;
      r_errc   <= 1'b0;
    end else begin
      if (HREADY) begin
        r_dval <= w_issue;
      end
      if (w_issue) begin
        r_dwe    <= biu_we_i;
        r_dwdata <= biu_d_i;
        r_dadr   <= biu_adri_i;
      end
      if (r_dval && w_err_first) begin
        r_errc <= 1'b1;
      end else if (HREADY) begin
        r_errc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_biu_ahb3lite_bridge.sv
// Directed bench for biu_ahb3lite_bridge; data-phase responses are checked against a queue
// of expected results pushed when each request is issued.
module tb_biu_ahb3lite_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        biu_stb_i;
  logic        biu_stb_ack_o;
  logic        biu_d_ack_o;
  logic [31:0] biu_adri_i;
  logic [31:0] biu_adro_o;
  logic [2:0]  biu_size_i;
  logic [2:0]  biu_type_i;
  logic        biu_lock_i;
  logic        biu_we_i;
  logic [3:0]  biu_prot_i;
  logic [31:0] biu_d_i;
  logic [31:0] biu_q_o;
  logic        biu_ack_o;
  logic        biu_err_o;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HRESP;

  biu_ahb3lite_bridge #(.XLEN(32), .ALEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .biu_stb_i(biu_stb_i), .biu_stb_ack_o(biu_stb_ack_o), .biu_d_ack_o(biu_d_ack_o),
    .biu_adri_i(biu_adri_i), .biu_adro_o(biu_adro_o), .biu_size_i(biu_size_i),
    .biu_type_i(biu_type_i), .biu_lock_i(biu_lock_i), .biu_we_i(biu_we_i),
    .biu_prot_i(biu_prot_i), .biu_d_i(biu_d_i), .biu_q_o(biu_q_o),
    .biu_ack_o(biu_ack_o), .biu_err_o(biu_err_o),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic        cmp_q;
    logic [31:0] q;
    logic        dack;
    logic [31:0] adr;
  } resp_t;

  resp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic err, input logic cmp_q, input logic [31:0] q,
                      input logic dack, input logic [31:0] adr);
    resp_t e;
    e.err = err; e.cmp_q = cmp_q; e.q = q; e.dack = dack; e.adr = adr;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic stb, input logic [31:0] adr, input logic we, input logic [31:0] d);
    biu_stb_i = stb; biu_adri_i = adr; biu_we_i = we; biu_d_i = d;
  endtask

  // Response monitor: every ack/err must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (biu_ack_o && biu_err_o) chk("ack_err_both", 1, 0);
      if (biu_ack_o || biu_err_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {biu_ack_o, biu_err_o}, 2'b00);
        end else begin
          resp_t e;
          e = sb.pop_front();
          chk("resp_err", biu_err_o, e.err);
          chk("resp_dack", biu_d_ack_o, e.dack);
          chk("resp_adro", biu_adro_o, e.adr);
          if (e.cmp_q) chk("resp_q", biu_q_o, e.q);
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    req(1'b1, 32'h0, 1'b0, 32'h0);
    biu_size_i = 3'd2; biu_type_i = 3'd0; biu_lock_i = 1'b0; biu_prot_i = 4'b0000;
    HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    #2;
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_hsel", HSEL, 0);
    chk("rst_stb_ack", biu_stb_ack_o, 0);
    chk("rst_ack_err", {biu_ack_o, biu_err_o, biu_d_ack_o}, 3'b000);
    chk("rst_hmastlock", HMASTLOCK, 0);
    tick(); tick();
    rst_ni = 1'b1;
    req(1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // 1: single read, zero wait states
    req(1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    chk("t1_htrans", HTRANS, 2'b10);
    chk("t1_stb_ack", biu_stb_ack_o, 1);
    chk("t1_haddr", HADDR, 32'h100);
    chk("t1_hsize", HSIZE, 3'd2);
    chk("t1_hwrite", HWRITE, 0);
    push(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h100);
    tick();
    req(1'b0, 32'h0, 1'b0, 32'h0);
    HRDATA = 32'hDEADBEEF;
    #1;
    chk("t1_ack", biu_ack_o, 1);
    chk("t1_idle", HTRANS, 2'b00);
    tick();

    // 2: back-to-back writes
    req(1'b1, 32'h10, 1'b1, 32'h11);
    #1;
    chk("t2_c0_htrans", HTRANS, 2'b10);
    push(1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    tick();
    req(1'b1, 32'h14, 1'b1, 32'h22);
    #1;
    chk("t2_c1_htrans", HTRANS, 2'b10);
    chk("t2_c1_hwdata", HWDATA, 32'h11);
    chk("t2_c1_dack", biu_d_ack_o, 1);
    push(1'b0, 1'b0, 32'h0, 1'b1, 32'h14);
    tick();
    req(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("t2_c2_hwdata", HWDATA, 32'h22);
    chk("t2_c2_dack", biu_d_ack_o, 1);
    tick();

    // 3: read with two wait states, next request held pending
    req(1'b1, 32'h200, 1'b0, 32'h0);
    push(1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h200);
    tick();
    req(1'b1, 32'h204, 1'b0, 32'h0);
    HREADY = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      #1;
      chk("t3_wait_htrans", HTRANS, 2'b00);
      chk("t3_wait_stb_ack", biu_stb_ack_o, 0);
      chk("t3_wait_ack", biu_ack_o, 0);
      tick();
    end
    HREADY = 1'b1;
    HRDATA = 32'hCAFEF00D;
    #1;
    chk("t3_c3_ack", biu_ack_o, 1);
    chk("t3_c3_htrans", HTRANS, 2'b10);
    push(1'b0, 1'b1, 32'h12345678, 1'b0, 32'h204);
    tick();
    req(1'b0, 32'h0, 1'b0, 32'h0);
    HRDATA = 32'h12345678;
    tick();

    // 4: write ERROR response, then retry
    req(1'b1, 32'h300, 1'b1, 32'h55);
    push(1'b1, 1'b0, 32'h0, 1'b0, 32'h300);
    tick();
    req(1'b1, 32'h304, 1'b1, 32'h66);
    HREADY = 1'b0; HRESP = 1'b1;
    #1;
    chk("t4_e1_htrans", HTRANS, 2'b00);
    chk("t4_e1_err", biu_err_o, 0);
    chk("t4_e1_ack", biu_ack_o, 0);
    tick();
    HREADY = 1'b1;
    #1;
    chk("t4_e2_htrans", HTRANS, 2'b00);
    chk("t4_e2_stb_ack", biu_stb_ack_o, 0);
    chk("t4_e2_err", biu_err_o, 1);
    chk("t4_e2_ack", biu_ack_o, 0);
    tick();
    HRESP = 1'b0;
    #1;
    chk("t4_retry_htrans", HTRANS, 2'b10);
    push(1'b0, 1'b0, 32'h0, 1'b1, 32'h304);
    tick();
    req(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("t4_retry_hwdata", HWDATA, 32'h66);
    tick();

    // 5: sizes, protection, lock, burst type ignored
    biu_prot_i = 4'b0010;
    biu_type_i = 3'd3;
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 32'h500 + 32'(4 * i), 1'b0, 32'h0);
      biu_size_i = 3'(i);
      biu_lock_i = i[0];
      if (i > 0) HRDATA = 32'hA0 + 32'(i - 1);
      #1;
      chk("t5_hsize", HSIZE, 3'(i));
      chk("t5_hprot", HPROT, 4'b0011);
      chk("t5_hmastlock", HMASTLOCK, i[0]);
      chk("t5_hburst", HBURST, 3'b000);
      push(1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0, 32'h500 + 32'(4 * i));
      tick();
    end
    req(1'b0, 32'h0, 1'b0, 32'h0);
    biu_lock_i = 1'b1;
    HRDATA = 32'hA3;
    #1;
    chk("t5_idle_lock", HMASTLOCK, 0);
    tick();
    biu_lock_i = 1'b0; biu_size_i = 3'd2; biu_type_i = 3'd0; biu_prot_i = 4'b0000;

    // 6: reset during a stalled data phase
    req(1'b1, 32'h400, 1'b1, 32'h77);
    tick();
    req(1'b0, 32'h0, 1'b0, 32'h0);
    HREADY = 1'b0;
    #1;
    chk("t6_adro", biu_adro_o, 32'h400);
    rst_ni = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_adro", biu_adro_o, 32'h0);
    chk("t6_rst_hwdata", HWDATA, 32'h0);
    chk("t6_rst_htrans", HTRANS, 2'b00);
    tick();
    rst_ni = 1'b1;
    HREADY = 1'b1;
    #1;
    chk("t6_post_ack", {biu_ack_o, biu_err_o}, 2'b00);
    chk("t6_post_htrans", HTRANS, 2'b00);
    tick(); tick();

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
